// File: rtl/riscie_mul_pkg.sv
// rtl/riscie_mul_pkg.sv - shared types for the radix-4 Booth MUL path
package riscie_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_t;

  localparam logic [4:0] ALU_CTL_MUL = 5'b00010;

  // Group is {b[2i+1], b[2i], b[2i-1]}; value = -2*g[2] + g[1] + g[0]
  function automatic booth_digit_t booth_encode(input logic [2:0] grp);
    case (grp)
      3'b001, 3'b010: return POS1;
      3'b011:         return POS2;
      3'b100:         return NEG2;
      3'b101, 3'b110: return NEG1;
      default:        return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_mul_unit_if.sv
// rtl/booth_mul_unit_if.sv - start/busy/done handshake and operand/result bus of the multiplier
interface booth_mul_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic             abort;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, is_signed, abort, a_in, b_in,
    input  busy, done, hi_out, lo_out
  );

  modport slave (
    input  start, is_signed, abort, a_in, b_in,
    output busy, done, hi_out, lo_out
  );
endinterface

// File: rtl/booth_r4_encoder.sv
// rtl/booth_r4_encoder.sv - combinational radix-4 Booth digit encoder
module booth_r4_encoder
  import riscie_mul_pkg::*;
(
  input  logic [2:0]   i_grp,
  output booth_digit_t o_digit
);

  assign o_digit = booth_encode(i_grp);

endmodule

// File: rtl/booth_mul_unit.sv
// rtl/booth_mul_unit.sv - multi-cycle radix-4 Booth multiplier, signed/unsigned, HI/LO result
module booth_mul_unit
  import riscie_mul_pkg::*;
#(
  parameter int WIDTH = 32
)(
  input  logic            i_clk,
  input  logic            i_clear_n,
  booth_mul_unit_if.slave bus
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int EW   = WIDTH + 2;
  localparam int AW   = 2 * WIDTH + 4;
  localparam int CW   = $clog2(ITER);

  mul_state_t              r_state;
  logic                    r_busy;
  logic                    r_done;
  logic [WIDTH-1:0]        r_hi;
  logic [WIDTH-1:0]        r_lo;
  logic [CW-1:0]           r_cnt;
  logic signed [AW-1:0]    r_acc;
  logic signed [EW-1:0]    r_a;
  logic [EW:0]             r_b;

  booth_digit_t            w_digit;
  logic signed [EW:0]      w_a1;
  logic signed [EW:0]      w_a2;
  logic signed [EW:0]      w_mult;
  logic signed [AW:0]      w_sum;
  logic signed [AW-1:0]    w_shr;
  logic signed [EW-1:0]    w_a_load;
  logic [EW-1:0]           w_b_load;
  logic                    w_last;

  assign w_a_load = bus.is_signed ? {{2{bus.a_in[WIDTH-1]}}, bus.a_in} : {2'b00, bus.a_in};
  assign w_b_load = bus.is_signed ? {{2{bus.b_in[WIDTH-1]}}, bus.b_in} : {2'b00, bus.b_in};

  booth_r4_encoder u_enc (
    .i_grp   (r_b[2:0]),
    .o_digit (w_digit)
  );

  assign w_a1 = {r_a[EW-1], r_a};
  assign w_a2 = {r_a, 1'b0};

  always_comb begin
    w_mult = '0;
    case (w_digit)
      POS1:    w_mult = w_a1;
      POS2:    w_mult = w_a2;
      NEG1:    w_mult = -w_a1;
      NEG2:    w_mult = -w_a2;
      default: w_mult = '0;
    endcase
  end

  // Digit multiple enters at the top; one guard bit keeps the pre-shift sum exact
  assign w_sum  = {r_acc[AW-1], r_acc} + {w_mult, {EW{1'b0}}};
  assign w_shr  = {w_sum[AW], w_sum[AW:2]};
  assign w_last = (r_cnt == CW'(ITER - 1));

  always_ff @(posedge i_clk) begin
    if (!i_clear_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_a     <= w_a_load;
            r_b     <= {w_b_load, 1'b0};
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CALC;
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_acc <= w_shr;
            r_b   <= r_b >> 2;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_hi    <= w_shr[2*WIDTH-1:WIDTH];
              r_lo    <= w_shr[WIDTH-1:0];
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.hi_out = r_hi;
  assign bus.lo_out = r_lo;

endmodule

// File: tb/tb_booth_mul_unit.sv
// tb/tb_booth_mul_unit.sv - self-checking bench for booth_mul_unit at WIDTH=8 and WIDTH=32
module tb_booth_mul_unit;

  logic clk = 1'b0;
  logic clear_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  booth_mul_unit_if #(.WIDTH(8))  bus8  ();
  booth_mul_unit_if #(.WIDTH(32)) bus32 ();

  booth_mul_unit #(.WIDTH(8)) u_dut8 (
    .i_clk     (clk),
    .i_clear_n (clear_n),
    .bus       (bus8)
  );

  booth_mul_unit #(.WIDTH(32)) u_dut32 (
    .i_clk     (clk),
    .i_clear_n (clear_n),
    .bus       (bus32)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input int w);
    longint      x;
    longint      y;
    logic [63:0] p;
    logic [63:0] mask;
    x = longint'({32'b0, a});
    y = longint'({32'b0, b});
    if (s) begin
      x = (x <<< (64 - w)) >>> (64 - w);
      y = (y <<< (64 - w)) >>> (64 - w);
    end
    p = 64'(x * y);
    mask = (w >= 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    return p & mask;
  endfunction

  // Called at the negedge of the n0-th cycle after the start edge
  task automatic wait32(input int n0, output int lat, output int bc);
    lat = -1;
    bc  = 0;
    for (int n = n0; n <= n0 + 40; n++) begin
      if (bus32.busy) bc++;
      if (bus32.done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [63:0] res, output int lat, output int bc);
    bus32.a_in      = a;
    bus32.b_in      = b;
    bus32.is_signed = s;
    bus32.start     = 1'b1;
    @(negedge clk);
    bus32.start = 1'b0;
    wait32(1, lat, bc);
    res = {bus32.hi_out, bus32.lo_out};
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      output logic [15:0] res, output int lat);
    bus8.a_in      = a;
    bus8.b_in      = b;
    bus8.is_signed = s;
    bus8.start     = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      if (bus8.done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    res = {bus8.hi_out, bus8.lo_out};
  endtask

  initial begin
    logic [63:0] res;
    logic [15:0] res8;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    int          lat;
    int          bc;
    int          dn;

    clear_n         = 1'b0;
    bus32.start     = 1'b0;
    bus32.is_signed = 1'b0;
    bus32.abort     = 1'b0;
    bus32.a_in      = '0;
    bus32.b_in      = '0;
    bus8.start      = 1'b0;
    bus8.is_signed  = 1'b0;
    bus8.abort      = 1'b0;
    bus8.a_in       = '0;
    bus8.b_in       = '0;
    repeat (3) @(negedge clk);

    check("rst_busy",  64'(bus32.busy), 64'd0);
    check("rst_done",  64'(bus32.done), 64'd0);
    check("rst_hilo",  {bus32.hi_out, bus32.lo_out}, 64'd0);
    check("rst_hilo8", 64'({bus8.hi_out, bus8.lo_out}), 64'd0);
    clear_n = 1'b1;
    @(negedge clk);

    run32(32'h22, 32'h24, 1'b0, res, lat, bc);
    check("t1_prod", res, 64'h0000_0000_0000_04C8);
    check("t1_latency", 64'(lat), 64'd18);
    check("t1_busy_cycles", 64'(bc), 64'd17);
    @(negedge clk);
    check("t1_done_pulse", 64'(bus32.done), 64'd0);
    check("t1_hold", {bus32.hi_out, bus32.lo_out}, 64'h4C8);

    run32(32'hFFFF_FFFE, 32'h3, 1'b1, res, lat, bc);
    check("t2_signed", res, 64'hFFFF_FFFF_FFFF_FFFA);
    run32(32'hFFFF_FFFE, 32'h3, 1'b0, res, lat, bc);
    check("t2_unsigned", res, 64'h0000_0002_FFFF_FFFA);

    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res, lat, bc);
    check("t3_umax", res, 64'hFFFF_FFFE_0000_0001);
    run32(32'h8000_0000, 32'h8000_0000, 1'b1, res, lat, bc);
    check("t3_smin", res, 64'h4000_0000_0000_0000);
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, res, lat, bc);
    check("t3_sneg1", res, 64'h0000_0000_0000_0001);

    run32(32'd5, 32'd6, 1'b0, res, lat, bc);
    check("t4_first", res, 64'd30);
    bus32.a_in      = 32'd7;
    bus32.b_in      = 32'd9;
    bus32.is_signed = 1'b0;
    bus32.start     = 1'b1;
    @(negedge clk);
    bus32.start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (n == 1 || n == 10) check("t4_held", {bus32.hi_out, bus32.lo_out}, 64'd30);
      if (bus32.done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    check("t4_b2b_latency", 64'(lat), 64'd18);
    check("t4_second", {bus32.hi_out, bus32.lo_out}, 64'h3F);

    @(negedge clk);
    bus32.a_in  = 32'd100;
    bus32.b_in  = 32'd200;
    bus32.start = 1'b1;
    @(negedge clk);
    bus32.start = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_busy_before_abort", 64'(bus32.busy), 64'd1);
    bus32.abort = 1'b1;
    @(negedge clk);
    bus32.abort = 1'b0;
    check("t5_busy_after_abort", 64'(bus32.busy), 64'd0);
    check("t5_done_after_abort", 64'(bus32.done), 64'd0);
    dn = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus32.done) dn++;
    end
    check("t5_no_done", 64'(dn), 64'd0);
    check("t5_result_kept", {bus32.hi_out, bus32.lo_out}, 64'h3F);

    bus32.a_in  = 32'd11;
    bus32.b_in  = 32'd13;
    bus32.start = 1'b1;
    @(negedge clk);
    bus32.start = 1'b0;
    repeat (2) @(negedge clk);
    bus32.a_in      = 32'd99;
    bus32.b_in      = 32'd99;
    bus32.is_signed = 1'b1;
    bus32.start     = 1'b1;
    @(negedge clk);
    bus32.start = 1'b0;
    wait32(4, lat, bc);
    check("t5_ignore_latency", 64'(lat), 64'd18);
    check("t5_ignore_result", {bus32.hi_out, bus32.lo_out}, 64'd143);

    @(negedge clk);
    bus32.a_in      = 32'd1234;
    bus32.b_in      = 32'd5678;
    bus32.is_signed = 1'b0;
    bus32.start     = 1'b1;
    @(negedge clk);
    bus32.start = 1'b0;
    repeat (4) @(negedge clk);
    clear_n = 1'b0;
    @(negedge clk);
    check("t6_busy", 64'(bus32.busy), 64'd0);
    check("t6_done", 64'(bus32.done), 64'd0);
    check("t6_hilo", {bus32.hi_out, bus32.lo_out}, 64'd0);
    clear_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 1500; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
      rs = 1'($urandom_range(0, 1));
      run32(ra, rb, rs, res, lat, bc);
      check("rand32", res, ref_mul(ra, rb, rs, 32));
    end

    for (int i = 0; i < 3000; i++) begin
      ra = $urandom & 32'hFF;
      rb = $urandom & 32'hFF;
      if ($urandom_range(0, 7) == 0) ra = 32'h80;
      if ($urandom_range(0, 7) == 0) rb = 32'hFF;
      rs = 1'($urandom_range(0, 1));
      run8(ra[7:0], rb[7:0], rs, res8, lat);
      check("rand8", 64'(res8), ref_mul(ra, rb, rs, 8));
      check("rand8_latency", 64'(lat), 64'd6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
